// File: rtl/imem_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory load controller.
//   state_e   : controller FSM states
//   instr_t   : instruction word layout (opcode / rs / rt / imm)
//   DEPTH     : number of valid instruction words in the memory
//   OPC_NOP / OPC_HLT : opcodes of interest to tools that inspect images
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int         DEPTH   = 69;
  localparam logic [5:0] OPC_NOP = 6'b010100;
  localparam logic [5:0] OPC_HLT = 6'b010111;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } instr_t;

  // True for opcodes that carry no datapath effect (padding / end of program).
  function automatic logic is_filler_opc(input logic [5:0] opc);
    return (opc == OPC_NOP) || (opc == OPC_HLT);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_if
// Bundles the loader byte stream, load control, fetch address and the
// instruction-memory write port of imem_load_ctrl.
//   master : the system side (loader, CPU fetch, memory observer)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              load_start;
  logic [ADDR_W-1:0] load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              cpu_stall;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_len, byte_valid, byte_data, cpu_addr,
    input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall,
           load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, cpu_addr,
    output byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall,
           load_busy, load_done, load_err
  );
endinterface

// File: rtl/imem_load_ctrl_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Collects four MSB-first bytes into one 32-bit instruction word.
//   clock, reset_n : clock / asynchronous active-low reset
//   clear_i        : restart word assembly (new image)
//   accept_i       : a byte is consumed this cycle
//   byte_i         : the byte being consumed
//   word_valid_o   : this accept completes a word (4th byte)
//   word_o         : assembled word; complete the cycle after word_valid_o
// -----------------------------------------------------------------------------
module byte_packer
  import imem_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       accept_i,
  input  logic [7:0] byte_i,
  output logic       word_valid_o,
  output instr_t     word_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept_i) begin
      // Shift left so the first byte of a word ends up in [31:24].
      shift_d = {shift_q[23:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_valid_o = accept_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = shift_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Owns the instruction-memory address/write port. In IDLE the fetch address
// passes straight through; during a load, bytes from a serial loader are
// packed into words and written to consecutive addresses from 0 while the
// CPU is stalled.
//   clock, reset_n : clock / asynchronous active-low reset
//   bus (slave)    : load_start/load_len, byte_valid/byte_data/byte_ready,
//                    cpu_addr, mem_addr/mem_wdata/mem_we, cpu_stall,
//                    load_busy, load_done, load_err
// -----------------------------------------------------------------------------
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = imem_pkg::DEPTH,
  parameter int TIMEOUT = 1024
) (
  input  logic           clock,
  input  logic           reset_n,
  imem_load_ctrl_if.slave bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic   byte_accept;
  logic   word_valid;
  logic   pack_clear;
  instr_t word;

  assign byte_accept = bus.byte_valid && (state_q == ST_RECV);

  byte_packer u_packer (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_i      (pack_clear),
    .accept_i     (byte_accept),
    .byte_i       (bus.byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    pack_clear = 1'b0;

    case (state_q)
      // ERR reacts to load_start exactly like IDLE; leaving ERR is what
      // clears the sticky error flag.
      ST_IDLE, ST_ERR: begin
        if (bus.load_start) begin
          if (bus.load_len > DEPTH_L) begin
            state_d = ST_ERR;
          end else if (bus.load_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RECV;
            len_d      = bus.load_len;
            word_cnt_d = '0;
            tmo_d      = '0;
            pack_clear = 1'b1;
          end
        end
      end

      ST_RECV: begin
        if (byte_accept) begin
          tmo_d = '0;
          if (word_valid) state_d = ST_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          // This is the TIMEOUT-th consecutive idle cycle.
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (word_cnt_d == len_q) ? ST_DONE : ST_RECV;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state only, so an asynchronous
  // reset forces them low immediately.
  assign bus.byte_ready = (state_q == ST_RECV);
  assign bus.mem_we     = (state_q == ST_WRITE);
  assign bus.mem_wdata  = (state_q == ST_WRITE) ? DATA_W'(word) : '0;
  assign bus.mem_addr   = (state_q == ST_IDLE) ? bus.cpu_addr : word_cnt_q;
  assign bus.cpu_stall  = (state_q != ST_IDLE);
  assign bus.load_busy  = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign bus.load_done  = (state_q == ST_DONE);
  assign bus.load_err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Self-checking bench for imem_load_ctrl. Expected memory contents are derived
// from the byte stream itself: word i at address i is bytes 4i..4i+3, MSB
// first. A monitor records every write; each scenario task checks its own
// results.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  imem_load_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  imem_load_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt;
  int          ready_seen;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        got_addr.push_back(bus.mem_addr);
        got_data.push_back(bus.mem_wdata);
        $display("write addr=%0d data=%08h", bus.mem_addr, bus.mem_wdata);
      end
      if (bus.load_done)  done_cnt++;
      if (bus.byte_ready) ready_seen++;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon;
    got_addr.delete();
    got_data.delete();
    done_cnt   = 0;
    ready_seen = 0;
  endtask

  task automatic start(input int len);
    bus.load_start = 1'b1;
    bus.load_len   = 10'(len);
    tick();
    bus.load_start = 1'b0;
  endtask

  // Present a byte (after an optional idle gap) and hold it until consumed.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (bus.byte_ready === 1'b1) ok = 1;
      tick();
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL byte_accept: byte %02h not accepted within 64 cycles", b);
    end
  endtask

  task automatic wait_done;
    for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
    compared++;
    if (done_cnt !== 1) begin
      mismatched++;
      $display("FAIL done_pulse: got %0d load_done pulses, expected 1", done_cnt);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick();
    compared++;
    if ({bus.byte_ready, bus.mem_we, bus.mem_wdata, bus.cpu_stall, bus.load_busy,
         bus.load_done, bus.load_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%b we=%b wdata=%h stall=%b busy=%b done=%b err=%b, expected all 0",
               bus.byte_ready, bus.mem_we, bus.mem_wdata, bus.cpu_stall, bus.load_busy,
               bus.load_done, bus.load_err);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_normal;
    logic [7:0] w0[4] = '{8'h34, 8'h00, 8'h00, 8'h01};
    logic [7:0] w1[4] = '{8'h58, 8'h00, 8'h00, 8'h00};
    clear_mon();
    start(2);
    compared++;
    if ({bus.byte_ready, bus.load_busy, bus.cpu_stall} !== 3'b111) begin
      mismatched++;
      $display("FAIL normal_recv: ready/busy/stall=%b expected 111",
               {bus.byte_ready, bus.load_busy, bus.cpu_stall});
    end
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin bus.byte_data = w0[i]; tick(); end
    compared++;
    if ({bus.mem_we, bus.byte_ready, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 10'd0, 32'h34000001}) begin
      mismatched++;
      $display("FAIL normal_write0: we=%b ready=%b addr=%0d data=%h expected we=1 ready=0 addr=0 data=34000001",
               bus.mem_we, bus.byte_ready, bus.mem_addr, bus.mem_wdata);
    end
    bus.byte_data = w1[0];
    tick();  // WRITE -> RECV, byte held but not consumed
    compared++;
    if ({bus.mem_we, bus.byte_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL normal_back_recv: we/ready=%b expected 01", {bus.mem_we, bus.byte_ready});
    end
    for (int i = 0; i < 4; i++) begin bus.byte_data = w1[i]; tick(); end
    bus.byte_valid = 1'b0;
    compared++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 10'd1, 32'h58000000}) begin
      mismatched++;
      $display("FAIL normal_write1: we=%b addr=%0d data=%h expected we=1 addr=1 data=58000000",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    compared++;
    if ({bus.load_done, bus.cpu_stall, bus.mem_we} !== 3'b110) begin
      mismatched++;
      $display("FAIL normal_done: done/stall/we=%b expected 110", {bus.load_done, bus.cpu_stall, bus.mem_we});
    end
    tick();
    compared++;
    if ({bus.load_done, bus.cpu_stall, got_addr.size()} !== {2'b00, 32'd2}) begin
      mismatched++;
      $display("FAIL normal_idle: done=%b stall=%b writes=%0d expected 0 0 2",
               bus.load_done, bus.cpu_stall, got_addr.size());
    end
  endtask

  task automatic test_zero;
    clear_mon();
    start(0);
    compared++;
    if ({bus.load_done, bus.cpu_stall, bus.byte_ready} !== 3'b110) begin
      mismatched++;
      $display("FAIL zero_done: done/stall/ready=%b expected 110", {bus.load_done, bus.cpu_stall, bus.byte_ready});
    end
    tick();
    tick();
    compared++;
    if ({bus.load_done, bus.cpu_stall} !== 2'b00 || got_addr.size() != 0 || ready_seen != 0 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL zero_after: done=%b stall=%b writes=%0d ready_cycles=%0d done_pulses=%0d expected 0 0 0 0 1",
               bus.load_done, bus.cpu_stall, got_addr.size(), ready_seen, done_cnt);
    end
  endtask

  task automatic test_oversize;
    logic [7:0] b[4];
    clear_mon();
    start(70);
    compared++;
    if ({bus.load_err, bus.cpu_stall, bus.byte_ready} !== 3'b110) begin
      mismatched++;
      $display("FAIL oversize_err: err/stall/ready=%b expected 110", {bus.load_err, bus.cpu_stall, bus.byte_ready});
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (5) tick();
    bus.byte_valid = 1'b0;
    compared++;
    if (bus.load_err !== 1'b1 || got_addr.size() != 0) begin
      mismatched++;
      $display("FAIL oversize_sticky: err=%b writes=%0d expected err=1 writes=0", bus.load_err, got_addr.size());
    end
    start(1);
    compared++;
    if ({bus.load_err, bus.byte_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL oversize_clear: err/ready=%b expected 01", {bus.load_err, bus.byte_ready});
    end
    for (int i = 0; i < 4; i++) begin b[i] = 8'($urandom); send_byte(b[i], 0); end
    bus.byte_valid = 1'b0;
    wait_done();
    compared++;
    if (got_addr.size() != 1 || got_addr[0] !== 10'd0 || got_data[0] !== {b[0], b[1], b[2], b[3]}) begin
      mismatched++;
      $display("FAIL oversize_reload: writes=%0d data=%h expected 1 write of %h at 0",
               got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, {b[0], b[1], b[2], b[3]});
    end
    tick();
  endtask

  task automatic test_timeout;
    int n = 0;
    clear_mon();
    start(1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bus.byte_valid = 1'b0;
    while (bus.load_err !== 1'b1 && n < 1100) begin tick(); n++; end
    compared++;
    if (bus.load_err !== 1'b1 || n < 1023 || n > 1026 || got_addr.size() != 0) begin
      mismatched++;
      $display("FAIL timeout: err=%b after %0d idle cycles, writes=%0d expected err=1 near 1024 cycles, 0 writes",
               bus.load_err, n, got_addr.size());
    end
    start(0);  // leave ERR through a zero-length load
    tick();
  endtask

  task automatic test_ignored_start;
    logic [7:0] b[8];
    bus.cpu_addr = 10'd43;
    tick();
    compared++;
    if (bus.mem_addr !== 10'd43) begin
      mismatched++;
      $display("FAIL idle_passthrough: mem_addr=%0d expected 43", bus.mem_addr);
    end
    clear_mon();
    start(2);
    compared++;
    if (bus.mem_addr !== 10'd0) begin
      mismatched++;
      $display("FAIL recv_addr: mem_addr=%0d expected 0", bus.mem_addr);
    end
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) send_byte(b[i], 0);
    bus.byte_valid = 1'b0;
    start(5);  // must be ignored while receiving
    for (int i = 3; i < 8; i++) send_byte(b[i], $urandom_range(0, 2));
    bus.byte_valid = 1'b0;
    wait_done();
    compared++;
    if (got_addr.size() != 2 || got_addr[0] !== 10'd0 || got_addr[1] !== 10'd1 ||
        got_data[0] !== {b[0], b[1], b[2], b[3]} || got_data[1] !== {b[4], b[5], b[6], b[7]}) begin
      mismatched++;
      $display("FAIL ignored_start: writes=%0d expected 2 writes %h,%h at 0,1",
               got_addr.size(), {b[0], b[1], b[2], b[3]}, {b[4], b[5], b[6], b[7]});
    end
    tick();
    compared++;
    if (bus.mem_addr !== 10'd43) begin
      mismatched++;
      $display("FAIL idle_return_addr: mem_addr=%0d expected 43", bus.mem_addr);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      logic [7:0] bytes[$];
      int n = (it == 0) ? 69 : $urandom_range(1, 6);
      bytes.delete();
      for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
      clear_mon();
      start(n);
      foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, 3));
      bus.byte_valid = 1'b0;
      wait_done();
      compared++;
      if (got_addr.size() != n || bus.load_err !== 1'b0) begin
        mismatched++;
        $display("FAIL random_count: it=%0d writes=%0d err=%b expected %0d writes err=0",
                 it, got_addr.size(), bus.load_err, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          compared++;
          if (got_addr[i] !== 10'(i) ||
              got_data[i] !== {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]}) begin
            mismatched++;
            $display("FAIL random_word: it=%0d idx=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                     it, i, got_addr[i], got_data[i], i,
                     {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]});
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    clear_mon();
    start(2);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 0);
    bus.byte_valid = 1'b0;
    bus.cpu_addr   = 10'd17;
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if ({bus.byte_ready, bus.mem_we, bus.mem_wdata, bus.cpu_stall, bus.load_busy,
         bus.load_done, bus.load_err} !== '0 || bus.mem_addr !== 10'd17 || got_addr.size() != 1) begin
      mismatched++;
      $display("FAIL async_reset: ready=%b we=%b stall=%b busy=%b done=%b err=%b addr=%0d writes=%0d expected zeros addr=17 writes=1",
               bus.byte_ready, bus.mem_we, bus.cpu_stall, bus.load_busy, bus.load_done,
               bus.load_err, bus.mem_addr, got_addr.size());
    end
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    bus.cpu_addr = 10'd99;
    tick();
    compared++;
    if (bus.mem_addr !== 10'd99 || bus.cpu_stall !== 1'b0 || bus.load_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL after_reset: addr=%0d stall=%b busy=%b expected 99 0 0",
               bus.mem_addr, bus.cpu_stall, bus.load_busy);
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.cpu_addr   = '0;
    reset_n        = 1'b0;
    done_cnt       = 0;
    ready_seen     = 0;
    test_reset();
    test_normal();
    test_zero();
    test_oversize();
    test_timeout();
    test_ignored_start();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
